// File: rtl/collapsering_pkg.sv
// Shared types and defaults for the collapse-ring controller.
// Holds the FSM state enum, default widths and synchroniser depth.
package collapsering_pkg;

    localparam int DEF_TRIM_W  = 28;
    localparam int DEF_MUX_W   = 3;
    localparam int DEF_CNT_W   = 16;
    localparam int SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/collapsering_ctrl_ring_edge_sync.sv
// Brings ring_clk into the wb_clk_i domain and emits a 1-cycle pulse
// per rising edge. Ports: clk_i, rst_i (sync, high), ring_i, pulse_o.
module ring_edge_sync
    import collapsering_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic ring_i,
    output logic pulse_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;
    logic                   pulse_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= '0;
            dly_q   <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], ring_i};
            dly_q   <= sync_q[SYNC_STAGES-1];
            pulse_q <= sync_q[SYNC_STAGES-1] & ~dly_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/collapsering_ctrl.sv
// Collapse-ring run controller: latches trims, starts the ring, counts
// its edges until collapse or window timeout, and reports the result.
// Ports: wb_clk_i/wb_rst_i, cfg_* config, cmd_start/cmd_abort requests,
// busy/result_* status, ring_* macro drive and ring_clk from the macro.
module collapsering_ctrl
    import collapsering_pkg::*;
#(
    parameter int TRIM_W        = DEF_TRIM_W,
    parameter int MUX_W         = DEF_MUX_W,
    parameter int CNT_W         = DEF_CNT_W,
    parameter int SETTLE_CYCLES = 4,
    parameter int QUIET_CYCLES  = 8
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [TRIM_W-1:0] cfg_trim_a,
    input  logic [TRIM_W-1:0] cfg_trim_b,
    input  logic [MUX_W-1:0]  cfg_clkmux,
    input  logic [CNT_W-1:0]  cfg_window,
    input  logic              cmd_start,
    input  logic              cmd_abort,
    output logic              busy,
    output logic              result_valid,
    output logic [CNT_W-1:0]  result_count,
    output logic              result_bit,
    output logic              result_timeout,
    output logic              ring_start,
    output logic [TRIM_W-1:0] ring_trim_a,
    output logic [TRIM_W-1:0] ring_trim_b,
    output logic [MUX_W-1:0]  ring_clkmux,
    input  logic              ring_clk
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] QUIET_N     = 8'(QUIET_CYCLES);

    state_e state_q, state_d;

    logic [7:0]        settle_q, settle_d;
    logic [7:0]        quiet_q, quiet_d;
    logic [CNT_W-1:0]  edge_q, edge_d;
    logic [CNT_W-1:0]  wcnt_q, wcnt_d;
    logic [CNT_W-1:0]  window_q;
    logic [TRIM_W-1:0] trim_a_q, trim_b_q;
    logic [MUX_W-1:0]  mux_q;
    logic [CNT_W-1:0]  res_cnt_q;
    logic              res_bit_q, res_to_q;

    logic edge_pulse;
    logic latch_cfg;
    logic collapse;
    logic expire;
    logic finish;

    ring_edge_sync u_sync (
        .clk_i   (wb_clk_i),
        .rst_i   (wb_rst_i),
        .ring_i  (ring_clk),
        .pulse_o (edge_pulse)
    );

    always_comb begin
        state_d   = state_q;
        settle_d  = settle_q;
        quiet_d   = quiet_q;
        edge_d    = edge_q;
        wcnt_d    = wcnt_q;
        latch_cfg = 1'b0;
        collapse  = 1'b0;
        expire    = 1'b0;
        finish    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_start && !cmd_abort) begin
                    latch_cfg = 1'b1;
                    settle_d  = '0;
                    state_d   = ARM;
                end
            end
            ARM: begin
                if (cmd_abort) begin
                    state_d = IDLE;
                end else begin
                    settle_d = settle_q + 8'd1;
                    if (settle_q == SETTLE_LAST) begin
                        quiet_d = '0;
                        edge_d  = '0;
                        wcnt_d  = '0;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (cmd_abort) begin
                    state_d = IDLE;
                end else begin
                    if (edge_pulse && edge_q != CNT_MAX)
                        edge_d = edge_q + CNT_ONE;
                    quiet_d  = edge_pulse ? 8'd0 : quiet_q + 8'd1;
                    wcnt_d   = wcnt_q + CNT_ONE;
                    collapse = (quiet_d == QUIET_N);
                    expire   = (window_q != '0) && (wcnt_d == window_q);
                    finish   = collapse || expire;
                    if (finish)
                        state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            settle_q  <= '0;
            quiet_q   <= '0;
            edge_q    <= '0;
            wcnt_q    <= '0;
            window_q  <= '0;
            trim_a_q  <= '0;
            trim_b_q  <= '0;
            mux_q     <= '0;
            res_cnt_q <= '0;
            res_bit_q <= 1'b0;
            res_to_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            quiet_q  <= quiet_d;
            edge_q   <= edge_d;
            wcnt_q   <= wcnt_d;
            if (latch_cfg) begin
                trim_a_q <= cfg_trim_a;
                trim_b_q <= cfg_trim_b;
                mux_q    <= cfg_clkmux;
                window_q <= cfg_window;
            end
            // Results are loaded on the RUN exit edge so they are
            // already stable while result_valid is high in DONE.
            if (finish) begin
                res_cnt_q <= edge_d;
                res_bit_q <= edge_d[0];
                res_to_q  <= !collapse;
            end
        end
    end

    assign busy           = (state_q != IDLE);
    assign ring_start     = (state_q == RUN);
    assign result_valid   = (state_q == DONE);
    assign result_count   = res_cnt_q;
    assign result_bit     = res_bit_q;
    assign result_timeout = res_to_q;
    assign ring_trim_a    = trim_a_q;
    assign ring_trim_b    = trim_b_q;
    assign ring_clkmux    = mux_q;

endmodule

// File: tb/tb_collapsering_ctrl.sv
// Directed bench for collapsering_ctrl with a clocked ring model.
// A second instance with a 4-bit counter covers saturation.
module tb_collapsering_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [27:0] cfg_trim_a = '0;
    logic [27:0] cfg_trim_b = '0;
    logic [2:0]  cfg_clkmux = '0;
    logic [15:0] cfg_window = '0;
    logic [3:0]  cfg_window4;
    logic        cmd_start = 1'b0;
    logic        cmd_abort = 1'b0;
    logic        ring_clk = 1'b0;

    logic        busy, rv, rbit, rto, ring_start;
    logic [15:0] rcnt;
    logic [27:0] ta, tb;
    logic [2:0]  mux;

    logic        busy4, rv4, rbit4, rto4, ring_start4;
    logic [3:0]  rcnt4;
    logic [27:0] ta4, tb4;
    logic [2:0]  mux4;

    int checks = 0;
    int errors = 0;
    int ring_left = 0;
    int ph = 0;

    assign cfg_window4 = cfg_window[3:0];

    always #5 clk = ~clk;

    collapsering_ctrl dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .cfg_trim_a(cfg_trim_a), .cfg_trim_b(cfg_trim_b),
        .cfg_clkmux(cfg_clkmux), .cfg_window(cfg_window),
        .cmd_start(cmd_start), .cmd_abort(cmd_abort),
        .busy(busy), .result_valid(rv), .result_count(rcnt),
        .result_bit(rbit), .result_timeout(rto),
        .ring_start(ring_start), .ring_trim_a(ta), .ring_trim_b(tb),
        .ring_clkmux(mux), .ring_clk(ring_clk)
    );

    collapsering_ctrl #(.CNT_W(4)) dut4 (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .cfg_trim_a(cfg_trim_a), .cfg_trim_b(cfg_trim_b),
        .cfg_clkmux(cfg_clkmux), .cfg_window(cfg_window4),
        .cmd_start(cmd_start), .cmd_abort(cmd_abort),
        .busy(busy4), .result_valid(rv4), .result_count(rcnt4),
        .result_bit(rbit4), .result_timeout(rto4),
        .ring_start(ring_start4), .ring_trim_a(ta4), .ring_trim_b(tb4),
        .ring_clkmux(mux4), .ring_clk(ring_clk)
    );

    // Ring model: while ring_start is high it toggles every 4 cycles
    // (8-cycle period) until ring_left rising edges are produced;
    // ring_left < 0 means run forever.
    always @(negedge clk) begin
        if (!ring_start) begin
            ring_clk = 1'b0;
            ph = 0;
        end else if (ring_left != 0 || ring_clk) begin
            ph = ph + 1;
            if (ph == 4) begin
                ph = 0;
                ring_clk = ~ring_clk;
                if (ring_clk && ring_left > 0)
                    ring_left = ring_left - 1;
            end
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rv(input int limit, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (rv) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic start_run();
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
    endtask

    logic ok;
    logic prev;
    logic seen;
    int   rises;

    initial begin
        // 1: reset and idle
        tick(3);
        rst = 1'b0;
        tick(20);
        chk("rst_busy", busy, 0);
        chk("rst_ring_start", ring_start, 0);
        chk("rst_rv", rv, 0);
        chk("rst_count", rcnt, 0);
        chk("rst_bit", rbit, 0);
        chk("rst_timeout", rto, 0);
        chk("rst_trim_a", ta, 0);
        chk("rst_trim_b", tb, 0);
        chk("rst_mux", mux, 0);

        // start together with abort in IDLE is ignored
        cmd_start = 1'b1;
        cmd_abort = 1'b1;
        tick();
        cmd_start = 1'b0;
        cmd_abort = 1'b0;
        chk("start_abort_ignored", busy, 0);

        // 2: 5 edges then collapse
        cfg_trim_a = 28'hABCDEF1;
        cfg_trim_b = 28'h1234567;
        cfg_clkmux = 3'd3;
        cfg_window = 16'd0;
        ring_left  = 5;
        start_run();
        chk("t2_busy", busy, 1);
        chk("t2_trim_a", ta, 28'hABCDEF1);
        chk("t2_trim_b", tb, 28'h1234567);
        chk("t2_mux", mux, 3);
        chk("t2_arm_start", ring_start, 0);
        tick(3);
        chk("t2_arm_end_start", ring_start, 0);
        tick();
        chk("t2_run_start", ring_start, 1);
        wait_rv(200, ok);
        chk("t2_done", ok, 1);
        chk("t2_count", rcnt, 5);
        chk("t2_bit", rbit, 1);
        chk("t2_timeout", rto, 0);
        chk("t2_count4", rcnt4, 5);
        chk("t2_done_start", ring_start, 0);
        tick();
        chk("t2_rv_pulse", rv, 0);
        chk("t2_idle_busy", busy, 0);
        chk("t2_trim_held", ta, 28'hABCDEF1);

        // 4: abort in RUN after 3 edges
        ring_left = -1;
        start_run();
        prev  = ring_clk;
        rises = 0;
        for (int i = 0; i < 200 && rises < 3; i++) begin
            tick();
            if (ring_clk && !prev)
                rises++;
            prev = ring_clk;
        end
        chk("t4_rises", rises, 3);
        tick(4);
        cmd_abort = 1'b1;
        tick();
        cmd_abort = 1'b0;
        chk("t4_start", ring_start, 0);
        chk("t4_busy", busy, 0);
        chk("t4_rv", rv, 0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            seen = seen | rv;
        end
        chk("t4_no_rv", seen, 0);
        chk("t4_count_kept", rcnt, 5);
        chk("t4_bit_kept", rbit, 1);

        // 3: timeout window 100, ring runs forever
        cfg_window = 16'd100;
        ring_left  = -1;
        start_run();
        wait_rv(300, ok);
        chk("t3_done", ok, 1);
        chk("t3_count", rcnt, 12);
        chk("t3_bit", rbit, 0);
        chk("t3_timeout", rto, 1);
        chk("t3_timeout4", rto4, 1);
        chk("t3_count4", rcnt4, 0);
        tick();
        chk("t3_idle", busy, 0);
        cfg_window = 16'd0;

        // 5: 20 edges, saturates the 4-bit instance
        ring_left = 20;
        start_run();
        wait_rv(400, ok);
        chk("t5_done", ok, 1);
        chk("t5_count", rcnt, 20);
        chk("t5_bit", rbit, 0);
        chk("t5_timeout", rto, 0);
        chk("t5_count4", rcnt4, 15);
        chk("t5_bit4", rbit4, 1);
        chk("t5_timeout4", rto4, 0);
        tick();

        // 6: start ignored in RUN, then reset mid-run
        cfg_trim_a = 28'h0000ABC;
        cfg_trim_b = 28'h0000DEF;
        ring_left  = -1;
        start_run();
        tick(10);
        chk("t6_running", ring_start, 1);
        cfg_trim_a = 28'h5555555;
        start_run();
        chk("t6_trim_kept", ta, 28'h0000ABC);
        chk("t6_busy", busy, 1);
        tick(3);
        chk("t6_trim_kept2", ta, 28'h0000ABC);
        chk("t6_still_run", ring_start, 1);
        rst = 1'b1;
        tick();
        chk("t6_rst_start", ring_start, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_trim_a", ta, 0);
        chk("t6_rst_trim_b", tb, 0);
        chk("t6_rst_mux", mux, 0);
        chk("t6_rst_count", rcnt, 0);
        chk("t6_rst_rv", rv, 0);
        chk("t6_rst_timeout", rto, 0);
        rst = 1'b0;
        tick(5);
        chk("t6_post_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
